// File: rtl/dac_sample_scheduler_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_sched_pkg;
    localparam int DAC_W = 12;
    localparam logic [DAC_W-1:0] RESET_SAMPLE = 12'd0;
    localparam logic MODE_PRIO = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_XFER} sched_state_t;

    typedef struct packed {
        logic             src;
        logic [DAC_W-1:0] data;
    } sample_t;
endpackage

// File: rtl/dac_sample_scheduler_if.sv
// Source handshakes and DAC driver link; master is the scheduler side.
interface dac_sched_if;
    import dac_sched_pkg::*;
    logic             a_valid, b_valid;
    logic [DAC_W-1:0] a_data, b_data;
    logic             a_ready, b_ready;
    logic [DAC_W-1:0] dac_data;
    logic             dac_start;
    logic             dac_busy;

    modport master (input a_valid, b_valid, a_data, b_data, dac_busy,
                    output a_ready, b_ready, dac_data, dac_start);
    modport slave  (output a_valid, b_valid, a_data, b_data, dac_busy,
                    input a_ready, b_ready, dac_data, dac_start);
endinterface

// File: rtl/dac_sample_scheduler_tick_divider.sv
// Sample-rate tick: one-cycle pulse every DIV cycles while enabled.
module tick_divider #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!enable || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/dac_sample_scheduler.sv
// Arbitrates two sample sources onto the MCP4725 driver at a fixed rate,
// tracking busy and flagging underrun, overrun and driver hangs.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SAMPLE_HZ    = 500,
    parameter int BUSY_TIMEOUT = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       mode,
    input  logic       clr,
    dac_sched_if.master bus,
    output logic       grant,
    output logic [7:0] underrun_cnt,
    output logic       overrun,
    output logic       timeout
);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);

    sched_state_t  state;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic          sel_a, sel_b;
    sample_t       pick;

    tick_divider #(.DIV(DIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Round-robin hands a tie to whichever source did not win last time.
    always_comb begin
        sel_a     = bus.a_valid && (mode == MODE_PRIO || !bus.b_valid || grant);
        sel_b     = bus.b_valid && !sel_a;
        pick.src  = sel_b;
        pick.data = sel_b ? bus.b_data : bus.a_data;
    end

    // Arbitration is registered on the tick edge so ready/data appear during LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            tcnt          <= '0;
            bus.dac_data  <= RESET_SAMPLE;
            bus.dac_start <= 1'b0;
            bus.a_ready   <= 1'b0;
            bus.b_ready   <= 1'b0;
            grant         <= 1'b0;
            underrun_cnt  <= '0;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            bus.a_ready <= 1'b0;
            bus.b_ready <= 1'b0;
            if (clr) begin
                underrun_cnt <= '0;
                overrun      <= 1'b0;
                timeout      <= 1'b0;
            end
            if (tick && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: if (tick) begin
                    state <= S_LOAD;
                    if (sel_a || sel_b) begin
                        bus.a_ready  <= sel_a;
                        bus.b_ready  <= sel_b;
                        bus.dac_data <= pick.data;
                        grant        <= pick.src;
                    end else begin
                        underrun_cnt <= (underrun_cnt == 8'hFF) ? underrun_cnt
                                                                : underrun_cnt + 8'd1;
                    end
                end
                S_LOAD: begin
                    state         <= S_START;
                    bus.dac_start <= 1'b1;
                    tcnt          <= '0;
                end
                S_START, S_XFER: begin
                    if (tcnt == T_LAST) begin
                        timeout       <= 1'b1;
                        bus.dac_start <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (state == S_START && bus.dac_busy) begin
                            state         <= S_XFER;
                            bus.dac_start <= 1'b0;
                        end else if (state == S_XFER && !bus.dac_busy) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Randomised and directed bench for dac_sample_scheduler against a transfer-level model.
module tb_dac_sample_scheduler;
    import dac_sched_pkg::*;

    localparam int DIV = 10;
    localparam int BT  = 50;

    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mode = 1'b0, clr = 1'b0;
    logic       grant, overrun, timeout;
    logic [7:0] underrun_cnt;
    dac_sched_if bus();

    dac_sample_scheduler #(.CLK_HZ(1000), .SAMPLE_HZ(100), .BUSY_TIMEOUT(BT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .clr          (clr),
        .bus          (bus),
        .grant        (grant),
        .underrun_cnt (underrun_cnt),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, t0 = 0;
    bit cmp_on = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transfer-level model: a transfer is alive for some age since its LOAD cycle.
    int         m_div = 0, m_age = 0, m_under = 0;
    bit         m_active = 0, m_seen = 0, m_grant = 0, m_ar = 0, m_br = 0, m_ovr = 0, m_tmo = 0;
    logic [11:0] m_data = 12'd0;

    task automatic m_reset();
        m_div = 0; m_age = 0; m_under = 0; m_active = 0; m_seen = 0;
        m_grant = 0; m_ar = 0; m_br = 0; m_ovr = 0; m_tmo = 0; m_data = 12'd0;
    endtask

    task automatic m_step();
        bit tk, take_b, inc, oset, tset;
        tk = enable && (m_div == DIV - 1);
        m_div = (!enable || tk) ? 0 : m_div + 1;
        m_ar = 0; m_br = 0; inc = 0; oset = 0; tset = 0; take_b = 0;
        if (!m_active) begin
            if (tk) begin
                m_active = 1; m_age = 0; m_seen = 0;
                if (!bus.a_valid && !bus.b_valid) inc = 1;
                else begin
                    take_b = !bus.a_valid || (mode == MODE_RR && bus.b_valid && !m_grant);
                    m_grant = take_b;
                    m_data = take_b ? bus.b_data : bus.a_data;
                    m_ar = !take_b;
                    m_br = take_b;
                end
            end
        end else begin
            if (tk) oset = 1;
            if (m_age == 0) m_age = 1;
            else if (m_age >= BT) begin
                m_active = 0; tset = 1;
            end else begin
                if (!m_seen && bus.dac_busy) m_seen = 1;
                else if (m_seen && !bus.dac_busy) m_active = 0;
                m_age++;
            end
        end
        if (inc) m_under = (m_under == 255) ? 255 : m_under + 1;
        else if (clr) m_under = 0;
        m_ovr = oset || (m_ovr && !clr);
        m_tmo = tset || (m_tmo && !clr);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) m_reset();
        else m_step();
    end

    initial forever begin
        @(negedge clk);
        #3;
        if (cmp_on) begin
            chk("a_ready", bus.a_ready, m_ar);
            chk("b_ready", bus.b_ready, m_br);
            chk("dac_data", bus.dac_data, m_data);
            chk("dac_start", bus.dac_start, m_active && m_age >= 1 && !m_seen);
            chk("grant", grant, m_grant);
            chk("underrun_cnt", underrun_cnt, m_under);
            chk("overrun", overrun, m_ovr);
            chk("timeout", timeout, m_tmo);
        end
    end

    // Driver and source behaviour, advanced once per negedge.
    int scnt = 0, hold = 0, delay = 3, hold_len = 5;
    bit drv_rnd = 0, drv_never = 0, src_rnd = 0;

    task automatic step();
        @(negedge clk);
        if (!rst_n) begin
            bus.dac_busy = 0; scnt = 0; hold = 0;
        end else if (bus.dac_busy) begin
            hold--;
            if (hold <= 0) bus.dac_busy = 0;
        end else if (bus.dac_start && !drv_never) begin
            if (scnt == 0 && drv_rnd)
                delay = ($urandom_range(0, 9) == 0) ? 80 : $urandom_range(1, 4);
            scnt++;
            if (scnt >= delay) begin
                bus.dac_busy = 1; scnt = 0;
                hold = drv_rnd ? $urandom_range(1, 14) : hold_len;
            end
        end else begin
            scnt = 0;
        end
        if (src_rnd) begin
            if (bus.a_ready) bus.a_valid = $urandom_range(0, 1) != 0;
            else if (!bus.a_valid) bus.a_valid = $urandom_range(0, 15) == 0;
            if (bus.a_ready || !bus.a_valid) bus.a_data = 12'($urandom);
            if (bus.b_ready) bus.b_valid = $urandom_range(0, 1) != 0;
            else if (!bus.b_valid) bus.b_valid = $urandom_range(0, 15) == 0;
            if (bus.b_ready || !bus.b_valid) bus.b_data = 12'($urandom);
        end
    endtask

    task automatic run_to(input int n);
        while ((cyc - t0) < n) step();
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) step();
        rst_n = 1;
        t0 = cyc;
    endtask

    initial begin
        int prev, rises;
        bit saw_b;
        bus.a_valid = 0; bus.b_valid = 0; bus.a_data = 0; bus.b_data = 0; bus.dac_busy = 0;
        repeat (3) step();
        cmp_on = 1;
        #2;
        chk("rst dac_data", bus.dac_data, 0);
        chk("rst dac_start", bus.dac_start, 0);
        chk("rst grant", grant, 0);
        chk("rst underrun", underrun_cnt, 0);

        // Basic transfer
        enable = 1; mode = MODE_PRIO;
        bus.a_valid = 1; bus.a_data = 12'hABC; bus.b_valid = 0;
        do_reset(2);
        run_to(9);  chk("t1 a_ready@9", bus.a_ready, 0);
        run_to(10); chk("t1 a_ready@10", bus.a_ready, 1);
        chk("t1 dac_data", bus.dac_data, 12'hABC);
        chk("t1 grant", grant, 0);
        run_to(11); chk("t1 start@11", bus.dac_start, 1);
        run_to(13); chk("t1 start@13", bus.dac_start, 1);
        run_to(14); chk("t1 start@14", bus.dac_start, 0);
        run_to(20); chk("t1 a_ready@20", bus.a_ready, 1);
        chk("t1 overrun", overrun, 0);

        // Round-robin
        mode = MODE_RR;
        bus.a_data = 12'h111; bus.b_valid = 1; bus.b_data = 12'h222;
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            run_to(10 + 10 * k);
            chk("t2 rr data", bus.dac_data, (k % 2 == 0) ? 12'h222 : 12'h111);
            chk("t2 rr grant", grant, (k % 2 == 0) ? 1 : 0);
        end

        // Fixed priority
        run_to(41);
        mode = MODE_PRIO;
        saw_b = 0;
        for (int c = 42; c <= 80; c++) begin
            run_to(c);
            if (bus.b_ready) saw_b = 1;
            if (c % 10 == 0) begin
                chk("t3 prio data", bus.dac_data, 12'h111);
                chk("t3 prio grant", grant, 0);
            end
        end
        chk("t3 b_ready never", saw_b, 0);

        // Underrun: 300 ticks with no source
        run_to(81);
        bus.a_valid = 0; bus.b_valid = 0;
        prev = bus.dac_start; rises = 0;
        for (int c = 82; c <= 3085; c++) begin
            run_to(c);
            if (bus.dac_start && prev == 0) rises++;
            prev = bus.dac_start;
            if (c == 1085) chk("t4 underrun@100", underrun_cnt, 100);
        end
        chk("t4 start pulses", rises, 300);
        chk("t4 underrun sat", underrun_cnt, 255);
        chk("t4 data held", bus.dac_data, 12'h111);

        // Overrun with a long busy
        bus.a_valid = 1; bus.a_data = 12'h5A5; hold_len = 12;
        do_reset(2);
        run_to(19); chk("t5 overrun@19", overrun, 0);
        run_to(20); chk("t5 overrun@20", overrun, 1);
        run_to(30); clr = 1;
        run_to(31); clr = 0;
        chk("t5 overrun clr", overrun, 0);

        // Driver hang
        drv_never = 1; hold_len = 5;
        do_reset(2);
        run_to(60); chk("t5 timeout@60", timeout, 0);
        chk("t5 start@60", bus.dac_start, 1);
        run_to(61); chk("t5 timeout@61", timeout, 1);
        chk("t5 start@61", bus.dac_start, 0);
        run_to(62); clr = 1;
        run_to(63); clr = 0;
        chk("t5 timeout clr", timeout, 0);
        chk("t5 overrun clr2", overrun, 0);
        drv_never = 0;

        // Reset mid-transfer
        bus.a_data = 12'h7E1;
        do_reset(2);
        run_to(15); chk("t6 data pre", bus.dac_data, 12'h7E1);
        rst_n = 0;
        #1;
        chk("t6 rst dac_data", bus.dac_data, 0);
        chk("t6 rst start", bus.dac_start, 0);
        chk("t6 rst a_ready", bus.a_ready, 0);
        do_reset(3);
        run_to(9);  chk("t6 a_ready@9", bus.a_ready, 0);
        run_to(10); chk("t6 a_ready@10", bus.a_ready, 1);

        // Random traffic, driver timing, mode, enable and clr
        src_rnd = 1; drv_rnd = 1;
        do_reset(2);
        for (int i = 0; i < 5000; i++) begin
            step();
            if (enable) enable = $urandom_range(0, 299) != 0;
            else enable = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            clr = $urandom_range(0, 63) == 0;
        end
        step();
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
